zq_cal_engine: RTL

- Hardware ZQ calibration sequencer between the PHY CSR block and the PHY analog backend.
- On a start request, runs a 7-bit successive-approximation (SAR) search on the ZQ code. Reads the backend comparator to decide each bit.
- Publishes the final code and status back to CSR. Otherwise drives the backend with a manual code, or with the last calibrated code.

---
 rtl/zq_cal_pkg.sv | 15 +
 rtl/zq_cal_sync.sv | 27 ++
 rtl/zq_cal_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/zq_cal_pkg.sv
// Shared types and constants for the ZQ calibration engine.
package zq_cal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } zq_cal_state_e;

    localparam int ZqCodeW    = 7;
    localparam int SettleCntW = 8;
    localparam int MajSamples = 3;

endpackage

// File: rtl/zq_cal_sync.sv
// Multi-flop synchronizer for asynchronous inputs; clears to 0 on reset.
module zq_cal_sync #(
    parameter int Stages = 2,
    parameter int Width  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Stages-1:0][Width-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/zq_cal_engine.sv
// ZQ calibration sequencer: SAR search of the ZQ code against the backend comparator.
// Build option ZQ_CAL_MAJORITY_EN: each bit is decided by a 2-of-3 vote over three samples.
module zq_cal_engine
    import zq_cal_pkg::*;
#(
    parameter int CodeW        = ZqCodeW,
    parameter int SettleCycles = 16,
    parameter int SyncStages   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             manual_en_i,
    input  logic [CodeW-1:0] manual_code_i,
    input  logic             manual_cal_en_i,
    input  logic             comparator_i,
    output logic [CodeW-1:0] zq_config_o,
    output logic             zq_cal_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CodeW-1:0] code_o,
    output logic             valid_o,
    output logic             sat_err_o
);

    localparam int                    IdxW       = (CodeW > 1) ? $clog2(CodeW) : 1;
    localparam logic [SettleCntW-1:0] SettleLoad = SettleCntW'(SettleCycles);
    localparam logic [IdxW-1:0]       TopIdx     = IdxW'(CodeW - 1);

    zq_cal_state_e         state_q, state_d;
    logic [SettleCntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CodeW-1:0]      cfg_q, cfg_d;
    logic [CodeW-1:0]      code_q, code_d;
    logic                  cal_en_q, cal_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  sat_q, sat_d;

    logic                  cmp_sync;
    logic                  decide;
    logic                  bit_val;
    logic [CodeW-1:0]      trial;
    logic [CodeW-1:0]      idle_cfg;

    zq_cal_sync #(
        .Stages(SyncStages),
        .Width (1)
    ) u_cmp_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (comparator_i),
        .q_o  (cmp_sync)
    );

    assign idle_cfg = manual_en_i ? manual_code_i : code_q;

`ifdef ZQ_CAL_MAJORITY_EN
    localparam logic [1:0] LastSamp = 2'(MajSamples - 1);

    logic [1:0] samp_q, samp_d;
    logic [1:0] votes_q, votes_d;
    logic [1:0] votes_tot;

    assign votes_tot = votes_q + {1'b0, cmp_sync};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        cfg_d    = cfg_q;
        code_d   = code_q;
        cal_en_d = cal_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        sat_d    = sat_q;
        decide   = 1'b0;
        bit_val  = 1'b0;
        trial    = cfg_q;
`ifdef ZQ_CAL_MAJORITY_EN
        samp_d   = samp_q;
        votes_d  = votes_q;
`endif

        unique case (state_q)
            IDLE: begin
                cfg_d    = idle_cfg;
                cal_en_d = manual_en_i & manual_cal_en_i;
                busy_d   = 1'b0;
                if (start_i && !abort_i) begin
                    state_d         = SETTLE;
                    cfg_d           = '0;
                    cfg_d[CodeW-1]  = 1'b1;
                    idx_d           = TopIdx;
                    cnt_d           = SettleLoad;
                    cal_en_d        = 1'b1;
                    busy_d          = 1'b1;
                    valid_d         = 1'b0;
                    sat_d           = 1'b0;
                end
            end

            SETTLE: begin
                cnt_d = cnt_q - SettleCntW'(1);
                if (cnt_q == SettleCntW'(1)) begin
                    state_d = SAMPLE;
`ifdef ZQ_CAL_MAJORITY_EN
                    samp_d  = '0;
                    votes_d = '0;
`endif
                end
            end

            SAMPLE: begin
`ifdef ZQ_CAL_MAJORITY_EN
                if (samp_q == LastSamp) begin
                    decide  = 1'b1;
                    bit_val = (votes_tot >= 2'd2);
                end else begin
                    samp_d  = samp_q + 2'd1;
                    votes_d = votes_tot;
                end
`else
                decide  = 1'b1;
                bit_val = cmp_sync;
`endif
                if (decide) begin
                    trial[idx_q] = bit_val;
                    if (idx_q != '0) begin
                        trial[idx_q - IdxW'(1)] = 1'b1;
                        idx_d   = idx_q - IdxW'(1);
                        cnt_d   = SettleLoad;
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                    cfg_d = trial;
                end
            end

            DONE: begin
                code_d   = cfg_q;
                valid_d  = 1'b1;
                sat_d    = (cfg_q == '0) || (cfg_q == '1);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                cal_en_d = 1'b0;
                cfg_d    = manual_en_i ? manual_code_i : cfg_q;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Abort only applies to an in-flight search; a finished result in DONE stands.
        if (abort_i && (state_q == SETTLE || state_q == SAMPLE)) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            cal_en_d = 1'b0;
            cfg_d    = idle_cfg;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            cfg_q    <= '0;
            code_q   <= '0;
            cal_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
`ifdef ZQ_CAL_MAJORITY_EN
            samp_q   <= '0;
            votes_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            cfg_q    <= cfg_d;
            code_q   <= code_d;
            cal_en_q <= cal_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
`ifdef ZQ_CAL_MAJORITY_EN
            samp_q   <= samp_d;
            votes_q  <= votes_d;
`endif
        end
    end

    assign zq_config_o = cfg_q;
    assign zq_cal_en_o = cal_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign code_o      = code_q;
    assign valid_o     = valid_q;
    assign sat_err_o   = sat_q;

endmodule
